// File: rtl/sram_access_controller.sv
// sram_access_controller: runs each 32-bit MEM-stage access as two 16-bit SRAM phases with wait states.
// Optional macro SRAM_RANGE_CHECK_EN: out-of-range requests skip the SRAM and pulse addr_err.
`default_nettype none

module sram_access_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter int          SRAM_ADDR_W = 18,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            ST_value,
  output logic [31:0]            memory_result,
  output logic                   ready,
  output logic                   addr_err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic                   wr_op;
  logic [SRAM_ADDR_W-2:0] word;
  logic [31:0]            wr_data;
  logic [15:0]            low_data;
  logic [31:0]            offset;
  logic                   req;
  logic                   out_of_range;
  logic                   unused_offset_bits;

  assign offset = alu_result - BASE;
  assign req    = mem_r_en | mem_w_en;
  // In IDLE a pending request must freeze the pipeline in the same cycle it appears.
  assign ready  = (state == IDLE) ? ~req : (state == DONE);
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
  assign out_of_range = (alu_result < BASE) || ((offset >> (SRAM_ADDR_W + 1)) != 32'd0);
`else
  assign out_of_range = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wr_op         <= 1'b0;
      word          <= '0;
      wr_data       <= '0;
      low_data      <= '0;
      memory_result <= '0;
      sram_addr     <= '0;
      sram_dq_out   <= '0;
      sram_dq_oe    <= 1'b0;
      sram_we_n     <= 1'b1;
      addr_err      <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wr_op    <= mem_w_en;
            word     <= offset[SRAM_ADDR_W:2];
            wr_data  <= ST_value;
            wait_cnt <= '0;
            if (out_of_range) begin
              state    <= DONE;
              addr_err <= 1'b1;
              if (!mem_w_en) memory_result <= '0;
            end else begin
              state       <= LOW;
              sram_addr   <= {offset[SRAM_ADDR_W:2], 1'b0};
              sram_dq_out <= ST_value[15:0];
              sram_dq_oe  <= mem_w_en;
              sram_we_n   <= ~mem_w_en;
            end
          end
        end
        LOW: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt    <= '0;
            low_data    <= sram_dq_in;
            sram_addr   <= {word, 1'b1};
            sram_dq_out <= wr_data[31:16];
            state       <= HIGH;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        HIGH: begin
          if (wait_cnt == LAST_WAIT) begin
            wait_cnt   <= '0;
            if (!wr_op) memory_result <= {sram_dq_in, low_data};
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_access_controller.sv
// tb_sram_access_controller: two DUTs (WAIT_CYCLES 1 and 3) checked every cycle against a timeline model.
`default_nettype none

module tb_sram_access_controller;

  localparam int W0 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       r_en, w_en, ready_o, err_o, soe, swe;
  logic [1:0][31:0] alu, st, mres_o;
  logic [1:0][17:0] saddr;
  logic [1:0][15:0] sdo, sdi;

  int checks = 0;
  int errors = 0;

  sram_access_controller #(.WAIT_CYCLES(W0), .SRAM_ADDR_W(18), .BASE_ADDR(1024)) u0 (
    .clock(clk), .reset(rst_n), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .alu_result(alu[0]), .ST_value(st[0]), .memory_result(mres_o[0]), .ready(ready_o[0]),
    .addr_err(err_o[0]), .sram_addr(saddr[0]), .sram_dq_out(sdo[0]), .sram_dq_in(sdi[0]),
    .sram_dq_oe(soe[0]), .sram_we_n(swe[0]));

  sram_access_controller #(.WAIT_CYCLES(W1), .SRAM_ADDR_W(18), .BASE_ADDR(1024)) u1 (
    .clock(clk), .reset(rst_n), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .alu_result(alu[1]), .ST_value(st[1]), .memory_result(mres_o[1]), .ready(ready_o[1]),
    .addr_err(err_o[1]), .sram_addr(saddr[1]), .sram_dq_out(sdo[1]), .sram_dq_in(sdi[1]),
    .sram_dq_oe(soe[1]), .sram_we_n(swe[1]));

  // External SRAM devices (one per DUT)
  bit [15:0] dev [2][262144];
  assign sdi[0] = dev[0][saddr[0]];
  assign sdi[1] = dev[1][saddr[1]];
  always @(posedge clk) begin
    if (!swe[0]) dev[0][saddr[0]] <= sdo[0];
    if (!swe[1]) dev[1][saddr[1]] <= sdo[1];
  end

  // Write-strobe log per DUT: {sram_addr[15:0], data} for each cycle with we_n low
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];
  always @(negedge clk) begin
    if (rst_n && !swe[0]) wq0.push_back({saddr[0][15:0], sdo[0]});
    if (rst_n && !swe[1]) wq1.push_back({saddr[1][15:0], sdo[1]});
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic bit range_err(input logic [31:0] a);
`ifdef SRAM_RANGE_CHECK_EN
    logic [31:0] off;
    off = a - 32'd1024;
    return (a < 32'd1024) || (off >= 32'h0008_0000);
`else
    return a[0] & 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: an access is a timeline; position 0 is the request cycle, phases fill 1..2W, then done.
  bit          busy [2];
  int          pos  [2];
  int          dpos [2];
  bit          opw  [2];
  bit          merr [2];
  logic [31:0] mdata[2];
  int unsigned wrd  [2];
  logic [31:0] mexp [2];
  bit [15:0]   exp_mem [2][262144];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        busy[k] = 1'b0; pos[k] = 0; mexp[k] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) begin
          if (pos[k] == dpos[k]) busy[k] = 1'b0;
          else begin
            pos[k]++;
            if (pos[k] == dpos[k] && !opw[k] && !merr[k])
              mexp[k] = {exp_mem[k][wrd[k]*2+1], exp_mem[k][wrd[k]*2]};
          end
        end else if (r_en[k] | w_en[k]) begin
          busy[k]  = 1'b1;
          pos[k]   = 1;
          opw[k]   = w_en[k];
          mdata[k] = st[k];
          wrd[k]   = ((alu[k] - 32'd1024) >> 2) % (1 << 17);
          merr[k]  = range_err(alu[k]);
          dpos[k]  = merr[k] ? 1 : 2 * wait_of(k) + 1;
          if (merr[k] && !opw[k]) mexp[k] = 32'd0;
          else if (opw[k] && !merr[k]) begin
            exp_mem[k][wrd[k]*2]   = st[k][15:0];
            exp_mem[k][wrd[k]*2+1] = st[k][31:16];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ph;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ph = busy[k] && (pos[k] < dpos[k]);
        chk("ready", k, ready_o[k], busy[k] ? (pos[k] == dpos[k]) : !(r_en[k] | w_en[k]));
        chk("we_n", k, swe[k], !(ph && opw[k]));
        chk("dq_oe", k, soe[k], ph && opw[k]);
        chk("memory_result", k, mres_o[k], mexp[k]);
        chk("addr_err", k, err_o[k], busy[k] && pos[k] == dpos[k] && merr[k]);
        if (ph) begin
          chk("sram_addr", k, saddr[k], 32'(wrd[k] * 2 + ((pos[k] > wait_of(k)) ? 1 : 0)));
          if (opw[k])
            chk("dq_out", k, sdo[k], (pos[k] <= wait_of(k)) ? mdata[k][15:0] : mdata[k][31:16]);
        end
      end
    end
  end

  function automatic int qsize(input int k);
    return (k == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [31:0] qget(input int k, input int i);
    return (k == 0) ? wq0[i] : wq1[i];
  endfunction

  // Drives one request after the next rising edge; returns at the DONE cycle with the latency.
  task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, output int lat);
    @(posedge clk); #1;
    r_en[k] = rd; w_en[k] = wr; alu[k] = a; st[k] = d;
    if (k == 0) wq0.delete(); else wq1.delete();
    lat = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ready_o[k]) begin
        lat = n;
        break;
      end
      if (scramble && n >= 1) begin
        #2;
        alu[k] = $urandom; st[k] = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          r_en[k] = 1'($urandom_range(0, 1)); w_en[k] = 1'($urandom_range(0, 1));
        end
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d no ready within 64 cycles", k);
    end
  endtask

  task automatic idle(input int k, input int n);
    @(posedge clk); #1;
    r_en[k] = 1'b0; w_en[k] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic rand_run(input int k);
    int lat, sel;
    logic [31:0] a;
    bit rd, wr;
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      access(k, rd, wr, a, $urandom, $urandom_range(0, 3) == 0, lat);
      if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
    end
    idle(k, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, w;
    logic [31:0] val, e;
    rst_n = 1'b0; r_en = '0; w_en = '0; alu = '0; st = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, ready_o[k], 1);
      chk("rst_we_n", k, swe[k], 1);
      chk("rst_oe", k, soe[k], 0);
      chk("rst_result", k, mres_o[k], 0);
      chk("rst_addr", k, saddr[k], 0);
    end

    for (int k = 0; k < 2; k++) begin
      w = wait_of(k);
      access(k, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, lat);
      chk("store_latency", k, lat, 2 * w + 1);
      chk("store_strobes", k, qsize(k), 2 * w);
      for (int i = 0; i < qsize(k); i++) begin
        e = (i < w) ? 32'h0002_BEEF : 32'h0003_DEAD;
        chk("store_bus", k, qget(k, i), e);
      end
      access(k, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, lat);
      chk("load_latency", k, lat, 2 * w + 1);
      chk("load_data", k, mres_o[k], 32'hDEADBEEF);

      val = 32'h1234_5678 ^ 32'(k);
      access(k, 1'b1, 1'b1, 32'd1032, val, 1'b0, lat);
      chk("both_latency", k, lat, 2 * w + 1);
      chk("both_strobes", k, qsize(k), 2 * w);
      for (int i = 0; i < qsize(k); i++) begin
        e = (i < w) ? {16'd4, val[15:0]} : {16'd5, val[31:16]};
        chk("both_bus", k, qget(k, i), e);
      end
      access(k, 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, lat);
      chk("b2b_latency", k, lat, 2 * w + 1);
      chk("b2b_data", k, mres_o[k], val);
      idle(k, 2);
    end

    access(0, 1'b1, 1'b0, 32'd100, 32'd0, 1'b0, lat);
`ifdef SRAM_RANGE_CHECK_EN
    chk("range_latency", 0, lat, 1);
    chk("range_err", 0, err_o[0], 1);
`else
    chk("range_latency", 0, lat, 3);
    chk("range_err", 0, err_o[0], 0);
`endif
    chk("range_strobes", 0, qsize(0), 0);
    idle(0, 2);

    fork
      rand_run(0);
      rand_run(1);
    join
    idle(0, 1);
    idle(1, 2);

    // Reset in the middle of a store's HIGH phase on the slow DUT
    @(posedge clk); #1;
    w_en[1] = 1'b1; alu[1] = 32'd1040; st[1] = 32'hCAFE_F00D;
    repeat (W1 + 2) @(negedge clk);
    chk("pre_reset_we_n", 1, swe[1], 0);
    chk("pre_reset_addr", 1, saddr[1], 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_we_n", 1, swe[1], 1);
    chk("mid_reset_oe", 1, soe[1], 0);
    chk("mid_reset_result", 1, mres_o[1], 0);
    w_en[1] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 1, ready_o[1], 1);
    chk("post_reset_ready", 0, ready_o[0], 1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Sequences 32-bit data-memory accesses from the MEM stage onto a 16-bit-wide external SRAM.
- Each word access is split into two half-word phases, low half first, with programmable wait states per phase.
- Drives a ready signal; the pipeline freezes all stages while ready is low.
- Replaces the single-cycle data memory path: the ALU result is the byte address and the store value is the write data.

Parameters:
- WAIT_CYCLES, 1, cycles per half-word phase (legal range 1..15).
- SRAM_ADDR_W, 18, SRAM half-word address width.
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request, held until ready.
- mem_w_en  in  1  store request, held until ready.
- alu_result  in  32  byte address.
- ST_value  in  32  store data.
- memory_result  out  32  load data; valid while ready=1 after a load.
- ready  out  1  0 = freeze pipeline.
- addr_err  out  1  out-of-range pulse (see Optional Feature).
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_oe  out  1  1 = controller drives the SRAM data bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low, with ports named clock and reset.
- Reset values (also applied on reset asserted mid-access):
  - State IDLE; access abandoned.
  - memory_result=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, addr_err=0.
- Address map:
  - offset = alu_result - BASE_ADDR (32-bit, wrap-around).
  - word = offset[SRAM_ADDR_W:2].
  - sram_addr = {word, half}, where half=0 for the low phase and half=1 for the high phase.
  - offset[1:0] is ignored.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en), combinational.
  - On a request: latch address, ST_value and op; clear wait counter; go to LOW.
  - If mem_r_en and mem_w_en are both high, the write wins.
- LOW:
  - sram_addr = {word,0}.
  - Write: sram_dq_out = data[15:0], sram_dq_oe=1, sram_we_n=0.
  - Read: sram_dq_oe=0, sram_we_n=1.
  - Stay WAIT_CYCLES cycles; on the last cycle capture sram_dq_in into result[15:0]; go to HIGH.
- HIGH:
  - Same as LOW with half=1 and data[31:16]; capture into result[31:16]; go to DONE.
- DONE:
  - ready=1 for exactly one cycle.
  - memory_result holds the assembled word (reads); for writes, memory_result is unchanged.
  - Unconditionally go to IDLE.
- Latency: request first seen in IDLE at cycle 0 -> ready=1 at cycle 2*WAIT_CYCLES+1. With WAIT_CYCLES=1, ready rises at cycle 3.
- Back-to-back requests: a request present in IDLE directly after DONE starts a new access with no extra bubble.
- Latched operands: request lines or operands changing mid-access have no effect; the access completes with latched values and DONE still pulses.
- Read hold: memory_result holds its value until the next read's DONE.
- Idle bus state: sram_we_n=1 and sram_dq_oe=0 in IDLE and DONE.
- ready is low in LOW and HIGH.

Optional Feature:
- Macro SRAM_RANGE_CHECK_EN.
- Defined:
  - In IDLE, a request with alu_result < BASE_ADDR or offset >= 2^(SRAM_ADDR_W+1) goes directly to DONE.
  - No SRAM activity: sram_we_n stays 1, sram_dq_oe stays 0.
  - memory_result=0 for reads.
  - addr_err=1 during that DONE cycle only.
  - Result: ready rises 1 cycle after the request.
- Not defined:
  - No range check; addresses wrap into the SRAM per the address map.
  - addr_err tied to 0.

Test Plan:
- Reset then release, no requests -> ready=1, sram_we_n=1, sram_dq_oe=0, memory_result=0.
- WAIT_CYCLES=1; store alu_result=1028, ST_value=0xDEADBEEF -> two SRAM writes:
  - sram_addr=2, data 0xBEEF;
  - then sram_addr=3, data 0xDEAD;
  - ready=1 at cycle 3.
- Load 1028 with the SRAM model returning the written data -> memory_result=0xDEADBEEF at the DONE cycle, ready low for 3 cycles. Repeat with WAIT_CYCLES=3 -> ready at cycle 7, each phase lasts 3 cycles.
- mem_r_en and mem_w_en both high at 1032 -> write performed, sram_we_n=0 in both phases; then a back-to-back load at 1032 -> starts the cycle after DONE and returns ST_value.
- Store in progress; assert reset during HIGH -> immediately sram_we_n=1, sram_dq_oe=0, state IDLE. After release, ready=1 with no request.
- SRAM_RANGE_CHECK_EN defined; load alu_result=100 -> addr_err=1 and ready=1 at cycle 1, memory_result=0, no SRAM strobes. Without the macro, the same access completes at cycle 3.
